// File: rtl/demux1_8_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux1_8_buf
// Brief    : Registered 1-to-8 demultiplexer, one holding register per lane,
//            valid/ready on both sides, unicast or broadcast routing.
// Revision : 1.0 - initial release
// ============================================================================
module demux1_8_buf (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_sel,
  input  logic         in_bcast,
  input  logic         flush,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [255:0] out_data,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned C_LANES = 8;
  localparam logic [15:0] C_DROP_MAX = 16'hFFFF;

  logic [7:0]  r_full;
  logic [15:0] r_drop_cnt;
  logic [7:0]  w_avail;
  logic        w_ready;
  logic        w_fire;
  logic [7:0]  w_load;

  // A lane can take a new word if empty or if it is being drained this cycle.
  assign w_avail = ~r_full | out_ready;

  always_comb begin
    w_ready = 1'b0;
    if (!rst && !flush) begin
      w_ready = in_bcast ? (&w_avail) : w_avail[in_sel];
    end
  end

  assign w_fire = in_valid & w_ready;

  always_comb begin
    w_load = 8'h00;
    if (w_fire) begin
      w_load = in_bcast ? 8'hFF : (8'h01 << in_sel);
    end
  end

  generate
    for (genvar k = 0; k < C_LANES; k++) begin : g_lane
      logic [31:0] r_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data    <= 32'h0;
          r_full[k] <= 1'b0;
        end else if (flush) begin
          r_full[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_data    <= in_data;
          r_full[k] <= 1'b1;
        end else if (out_ready[k]) begin
          r_full[k] <= 1'b0;
        end
      end

      assign out_data[32*k +: 32] = r_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 16'h0;
    end else if (in_valid && !w_ready && (r_drop_cnt != C_DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + 16'h1;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_full;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux1_8_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1_8_buf
// Brief    : Directed and randomized bench for demux1_8_buf against a
//            lane-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux1_8_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast;
  logic         flush;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic [15:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full [8];
  logic [31:0] m_data [8];
  int          m_drop;

  always #5 clk = ~clk;

  demux1_8_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input logic [2:0] s, input logic b, input logic f,
                                     input logic r, input logic [7:0] ordy);
    int free_lanes = 0;
    if (r || f) return 1'b0;
    for (int k = 0; k < 8; k++)
      if (!m_full[k] || ordy[k]) free_lanes++;
    if (b) return (free_lanes == 8);
    return (!m_full[s] || ordy[s]);
  endfunction

  function automatic logic [255:0] model_out_data();
    logic [255:0] v = '0;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = m_data[k];
    return v;
  endfunction

  function automatic logic [7:0] model_out_valid();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, clock, check outputs.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] s,
                       input logic b, input logic f, input logic [7:0] ordy,
                       input logic r, input bit chk);
    bit rdy;
    in_valid = v; in_data = d; in_sel = s; in_bcast = b;
    flush = f; out_ready = ordy; rst = r;
    #1;
    rdy = model_ready(s, b, f, r, ordy);
    if (chk) check("in_ready", {255'b0, in_ready}, {255'b0, rdy});
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 8; k++) begin m_full[k] = 0; m_data[k] = '0; end
      m_drop = 0;
    end else begin
      if (v && !rdy && m_drop < 65535) m_drop++;
      for (int k = 0; k < 8; k++) begin
        if (f) m_full[k] = 0;
        else if (v && rdy && (b || s == k)) begin
          m_data[k] = d; m_full[k] = 1;
        end else if (ordy[k]) m_full[k] = 0;
      end
    end
    #1;
    if (chk) begin
      check("out_valid", {248'b0, out_valid}, {248'b0, model_out_valid()});
      check("out_data", out_data, model_out_data());
      check("drop_cnt", {240'b0, drop_cnt}, 256'(m_drop));
    end
    @(negedge clk);
  endtask

  initial begin
    int dc;
    rst = 1; in_valid = 0; in_data = '0; in_sel = '0; in_bcast = 0;
    flush = 0; out_ready = '0;
    for (int k = 0; k < 8; k++) begin m_full[k] = 0; m_data[k] = '0; end
    m_drop = 0;
    @(negedge clk);

    // Reset held two cycles with in_valid asserted
    cycle(1, 32'h5555_5555, 3'd1, 0, 0, 8'hFF, 1, 1);
    cycle(1, 32'h5555_5555, 3'd6, 0, 0, 8'hFF, 1, 1);
    check("reset_drop", {240'b0, drop_cnt}, 256'h0);

    // Unicast sweep, no stall
    for (int s = 0; s < 8; s++)
      cycle(1, 32'hA000_0000 | 32'(s), 3'(s), 0, 0, 8'hFF, 0, 1);
    check("sweep_lane7", {224'b0, out_data[255:224]}, {224'b0, 32'hA000_0007});
    cycle(0, 0, 0, 0, 0, 8'hFF, 0, 1);

    // Lane backpressure
    cycle(1, 32'h1111_1111, 3'd3, 0, 0, 8'h00, 0, 1);
    cycle(1, 32'h2222_2222, 3'd3, 0, 0, 8'h00, 0, 1);
    cycle(1, 32'h2222_2222, 3'd3, 0, 0, 8'h00, 0, 1);
    check("bp_drop", {240'b0, drop_cnt}, 256'd2);
    cycle(1, 32'h3333_3333, 3'd5, 0, 0, 8'h00, 0, 1);
    cycle(1, 32'h2222_2222, 3'd3, 0, 0, 8'h08, 0, 1);
    check("bp_lane3", {224'b0, out_data[127:96]}, {224'b0, 32'h2222_2222});
    cycle(0, 0, 0, 0, 0, 8'hFF, 0, 1);

    // Broadcast, then broadcast blocked by stalled lane 6
    cycle(1, 32'hDEAD_BEEF, 3'd2, 1, 0, 8'h00, 0, 1);
    check("bcast_valid", {248'b0, out_valid}, {248'b0, 8'hFF});
    cycle(0, 0, 0, 0, 0, 8'hBF, 0, 1);
    cycle(1, 32'hCAFE_F00D, 3'd0, 1, 0, 8'hBF, 0, 1);
    check("bcast_stall_lane6", {224'b0, out_data[223:192]}, {224'b0, 32'hDEAD_BEEF});
    cycle(0, 0, 0, 0, 0, 8'hFF, 0, 1);

    // Flush with in_valid, then reset mid-operation
    cycle(1, 32'h0000_00F0, 3'd0, 0, 0, 8'h00, 0, 1);
    cycle(1, 32'h0000_00F2, 3'd2, 0, 0, 8'h00, 0, 1);
    cycle(1, 32'h0000_00F7, 3'd7, 0, 0, 8'h00, 0, 1);
    dc = m_drop;
    cycle(1, 32'h0000_0BAD, 3'd4, 0, 1, 8'h00, 0, 1);
    check("flush_valid", {248'b0, out_valid}, 256'h0);
    check("flush_drop", {240'b0, drop_cnt}, 256'(dc + 1));
    cycle(1, 32'h0000_02F2, 3'd2, 0, 0, 8'h00, 0, 1);
    cycle(0, 0, 0, 0, 0, 8'h00, 1, 1);
    check("rst_data", out_data, 256'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
            8'($urandom), 1'($urandom_range(0, 63) == 0), 1);

    // drop_cnt saturation
    cycle(0, 0, 0, 0, 0, 8'h00, 1, 1);
    cycle(1, 32'h0BAD_F00D, 3'd4, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 65540; i++)
      cycle(1, 32'h1234_5678, 3'd4, 0, 0, 8'h00, 0, 0);
    check("drop_sat", {240'b0, drop_cnt}, {240'b0, 16'hFFFF});
    cycle(1, 32'h1234_5678, 3'd4, 0, 0, 8'h00, 0, 1);
    check("drop_nowrap", {240'b0, drop_cnt}, {240'b0, 16'hFFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux1_8_buf.md
# demux1_8_buf

Registered 1-to-8 demultiplexer with one holding register per lane and valid/ready handshakes on both sides. It is the distribution-side counterpart of the 8-to-1 source select in the 54-instruction CPU datapath. It routes one 32-bit word per cycle from a single producer to one of eight consumers selected by a 3-bit code, or to all eight at once in broadcast mode. Typical uses are fanning a result bus out to per-unit inputs and driving 8-way write-back targets.

## Interface
- No parameters. Data width is fixed at 32 and lane count at 8.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  32  word to route
- in_sel  in  3  destination lane 0..7; s=0 maps to lane 0 ... s=7 maps to lane 7
- in_bcast  in  1  when 1, write the word to all 8 lanes; in_sel is ignored
- flush  in  1  clear all lane registers
- out_valid  out  8  bit k set means lane k holds a word
- out_ready  in  8  bit k set means consumer k takes lane k's word this cycle
- out_data  out  256  lane k's word at bits [32k+31:32k]
- drop_cnt  out  16  count of cycles on which in_valid was held off (in_valid=1, in_ready=0); saturating

## Operation
- Each lane k has a 32-bit data register D[k] and a full flag F[k]. out_valid[k]=F[k] and out_data lane k=D[k]. Outputs come straight from registers, with no combinational path from in_* to out_*.
- Lane k can accept when avail[k] = ~F[k] | out_ready[k]. This allows same-cycle drain and refill.
- in_ready:
  - Unicast (in_bcast=0): in_ready = avail[in_sel].
  - Broadcast (in_bcast=1): in_ready = AND of avail[0..7].
  - Forced 0 when flush=1 or rst=1.
- in_ready may depend combinationally on in_sel, in_bcast, out_ready and flush. It never depends on in_valid.
- Input transfer happens when in_valid & in_ready:
  - Unicast: D[in_sel]<=in_data and F[in_sel]<=1.
  - Broadcast: D[k]<=in_data and F[k]<=1 for every k.
- Output transfer on lane k happens when F[k] & out_ready[k]. F[k]<=0 unless a new input transfer targets lane k in the same cycle, in which case F[k] stays 1 with the new data.
- Lanes whose consumers are ready have no effect on other lanes. A stalled lane blocks only unicast traffic addressed to it, plus all broadcasts.
- flush=1: all F<=0 next edge; D is unchanged. No input is accepted that cycle. Outputs asserted during that cycle still count as delivered to the consumers.
- drop_cnt increments by 1 on each cycle with in_valid=1 and in_ready=0. It saturates at 16'hFFFF. It is cleared only by rst, not by flush.
- out_ready[k] with F[k]=0 is ignored.

## Timing
- Reset values: F=8'h00, D[k]=32'h0, drop_cnt=16'h0. Consequently out_valid=8'h00, out_data=256'h0, and in_ready=0 during the reset cycle.
- Reset mid-operation discards every held word. No output transfer is considered to occur in the reset cycle.
- Latency is 1 cycle: a word accepted at edge N appears on its lane's out_data with out_valid high after edge N.
- Throughput is 1 word per cycle per lane. Sustained unicast to one lane needs out_ready held high.
- Full-lane boundary: with F[k]=1 and out_ready[k]=0, a unicast to lane k stalls and D[k] holds. Once out_ready[k] rises, the pending word is accepted in that same cycle.
- Priority within a cycle is rst > flush > transfers.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=00, out_data=0, in_ready=0, drop_cnt=0 throughout. Release rst -> in_ready=1 for any in_sel.
- Unicast sweep: out_ready=FF, send in_data=32'hA000_000s for s=0..7 on consecutive cycles -> lane s shows A000_000s with one-hot out_valid one cycle later. Every word is accepted with no stall.
- Lane backpressure: out_ready=00, send 32'h1111_1111 to lane 3, then 32'h2222_2222 to lane 3, then 32'h3333_3333 to lane 5. Required response:
  - Second word stalls; drop_cnt counts 1 per stalled cycle.
  - Lane 5 is still reachable once the producer switches in_sel.
  - Raising out_ready[3] accepts 2222_2222 that cycle, and it appears the next cycle.
- Broadcast: lanes idle, in_bcast=1, in_data=32'hDEAD_BEEF -> out_valid=FF and all lanes read DEAD_BEEF. With lane 6 full and out_ready[6]=0, a broadcast stalls (in_ready=0) and no lane changes.
- Flush and reset mid-operation:
  - Fill lanes 0, 2, 7, then pulse flush with in_valid=1 -> in_ready=0 that cycle and out_valid=00 after the edge. drop_cnt keeps its value plus 1.
  - Refill lane 2, then assert rst -> all outputs return to reset values.
- drop_cnt saturation: force 65540 stall cycles -> drop_cnt stops at FFFF and does not wrap.
